// File: rtl/memory_access_pkg.sv
// Shared types and constants for the memory access stage.
// Access type codes match the downstream load-extension stage.
package memory_access_pkg;

  localparam int MEMORY_DATA_W     = 32;
  localparam int MEMORY_WRAP_TYP_W = 3;
  localparam int MEMORY_BE_W       = 4;

  localparam logic [MEMORY_WRAP_TYP_W-1:0] MEMORY_WRAP_TYP_BS = 3'd0;
  localparam logic [MEMORY_WRAP_TYP_W-1:0] MEMORY_WRAP_TYP_HS = 3'd1;
  localparam logic [MEMORY_WRAP_TYP_W-1:0] MEMORY_WRAP_TYP_WS = 3'd2;
  localparam logic [MEMORY_WRAP_TYP_W-1:0] MEMORY_WRAP_TYP_BU = 3'd4;
  localparam logic [MEMORY_WRAP_TYP_W-1:0] MEMORY_WRAP_TYP_HU = 3'd5;

  localparam logic [1:0] MEMORY_ACCESS_ST_IDLE = 2'd0;
  localparam logic [1:0] MEMORY_ACCESS_ST_BUS  = 2'd1;
  localparam logic [1:0] MEMORY_ACCESS_ST_RESP = 2'd2;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  // Request context kept across the bus cycle
  typedef struct packed {
    logic       we;
    logic [1:0] off;   // effective (aligned) byte offset
  } req_ctx_t;

  // Unknown type codes fall through to word size
  function automatic size_e typ_size(input logic [MEMORY_WRAP_TYP_W-1:0] typ);
    case (typ)
      MEMORY_WRAP_TYP_BS, MEMORY_WRAP_TYP_BU: typ_size = SZ_B;
      MEMORY_WRAP_TYP_HS, MEMORY_WRAP_TYP_HU: typ_size = SZ_H;
      default:                                typ_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/memory_lane.sv
// Byte-lane decode: byte enables, lane-replicated store data, aligned
// offset (also used to shift load data) and the misaligned flag.
module memory_lane
  import memory_access_pkg::*;
(
  input  logic [MEMORY_WRAP_TYP_W-1:0] typ,
  input  logic [1:0]                   off,
  input  logic [MEMORY_DATA_W-1:0]     wdata,
  output logic [MEMORY_BE_W-1:0]       be,
  output logic [MEMORY_DATA_W-1:0]     wdata_rep,
  output logic [1:0]                   off_eff,
  output logic                         misaligned
);

  // Size-dependent lane selection; off_eff is off masked to natural alignment
  always_comb begin
    be         = 4'b1111;
    wdata_rep  = wdata;
    off_eff    = 2'b00;
    misaligned = 1'b0;
    case (typ_size(typ))
      SZ_B: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        off_eff   = off;
      end
      SZ_H: begin
        be         = off[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        off_eff    = {off[1], 1'b0};
        misaligned = off[0];
      end
      default: begin
        be         = 4'b1111;
        wdata_rep  = wdata;
        off_eff    = 2'b00;
        misaligned = |off;
      end
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Load/store access stage: one request at a time onto a word-addressed
// data bus, waits for ack or timeout, returns the shifted load word.
// Optional macro MEMORY_MISALIGN_TRAP_EN: misaligned requests respond with
// an error and no bus cycle; otherwise the offset is forced aligned.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [MEMORY_WRAP_TYP_W-1:0] req_typ,
  input  logic [31:0]                  req_addr,
  input  logic [MEMORY_DATA_W-1:0]     req_wdata,
  output logic                         resp_valid,
  output logic [MEMORY_DATA_W-1:0]     resp_data,
  output logic [MEMORY_WRAP_TYP_W-1:0] resp_typ,
  output logic                         resp_err,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [31:0]                  mem_addr,
  output logic [MEMORY_BE_W-1:0]       mem_be,
  output logic [MEMORY_DATA_W-1:0]     mem_wdata,
  input  logic                         mem_ack,
  input  logic [MEMORY_DATA_W-1:0]     mem_rdata
);

  localparam int unsigned   TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [15:0]   TO_LAST   = TO_LAST_I[15:0];
  localparam logic          TO_EN     = (TIMEOUT != 0);

  logic [1:0]               state;
  logic [15:0]              tmo_cnt;
  req_ctx_t                 ctx;

  logic [MEMORY_BE_W-1:0]   lane_be;
  logic [MEMORY_DATA_W-1:0] lane_wdata;
  logic [1:0]               lane_off;
  logic                     lane_mis;
  logic                     trap;
  logic                     tmo_hit;
  logic [MEMORY_DATA_W-1:0] rdata_shift;

  memory_lane u_lane (
    .typ        (req_typ),
    .off        (req_addr[1:0]),
    .wdata      (req_wdata),
    .be         (lane_be),
    .wdata_rep  (lane_wdata),
    .off_eff    (lane_off),
    .misaligned (lane_mis)
  );

`ifdef MEMORY_MISALIGN_TRAP_EN
  assign trap = lane_mis;
`else
  logic unused_mis;
  assign unused_mis = lane_mis;
  assign trap       = 1'b0;
`endif

  assign req_ready   = (state == MEMORY_ACCESS_ST_IDLE);
  assign mem_req     = (state == MEMORY_ACCESS_ST_BUS);
  assign resp_valid  = (state == MEMORY_ACCESS_ST_RESP);
  assign tmo_hit     = TO_EN && (tmo_cnt == TO_LAST);
  assign rdata_shift = mem_rdata >> {ctx.off, 3'b000};

  // Request/bus/response sequencing; ack takes priority over timeout
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= MEMORY_ACCESS_ST_IDLE;
      tmo_cnt   <= '0;
      ctx       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      resp_data <= '0;
      resp_typ  <= '0;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        MEMORY_ACCESS_ST_IDLE: begin
          if (req_valid) begin
            ctx       <= '{we: req_we, off: lane_off};
            mem_we    <= req_we;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_be    <= req_we ? lane_be : 4'b1111;
            mem_wdata <= lane_wdata;
            resp_typ  <= req_typ;
            resp_data <= '0;
            tmo_cnt   <= '0;
            if (trap) begin
              resp_err <= 1'b1;
              state    <= MEMORY_ACCESS_ST_RESP;
            end else begin
              resp_err <= 1'b0;
              state    <= MEMORY_ACCESS_ST_BUS;
            end
          end
        end
        MEMORY_ACCESS_ST_BUS: begin
          if (mem_ack) begin
            resp_data <= ctx.we ? '0 : rdata_shift;
            state     <= MEMORY_ACCESS_ST_RESP;
          end else if (tmo_hit) begin
            resp_err  <= 1'b1;
            state     <= MEMORY_ACCESS_ST_RESP;
          end else begin
            tmo_cnt   <= tmo_cnt + 16'd1;
          end
        end
        MEMORY_ACCESS_ST_RESP: state <= MEMORY_ACCESS_ST_IDLE;
        default:               state <= MEMORY_ACCESS_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: table of single transactions plus
// hand sequences for timeout, ack/timeout tie, misalignment and reset.
module tb_memory_access;
  import memory_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [2:0]  req_typ;
  logic [31:0] req_addr, req_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        req_ready, resp_valid, resp_err, mem_req, mem_we;
  logic [31:0] resp_data, mem_addr, mem_wdata;
  logic [2:0]  resp_typ;
  logic [3:0]  mem_be;

  logic        t4_req_ready, t4_resp_valid, t4_resp_err, t4_mem_req, t4_mem_we;
  logic [31:0] t4_resp_data, t4_mem_addr, t4_mem_wdata;
  logic [2:0]  t4_resp_typ;
  logic [3:0]  t4_mem_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_access dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_typ(req_typ), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_typ(resp_typ),
    .resp_err(resp_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  memory_access #(.TIMEOUT(4)) dut_t4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(t4_req_ready),
    .req_we(req_we), .req_typ(req_typ), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(t4_resp_valid), .resp_data(t4_resp_data), .resp_typ(t4_resp_typ),
    .resp_err(t4_resp_err), .mem_req(t4_mem_req), .mem_we(t4_mem_we),
    .mem_addr(t4_mem_addr), .mem_be(t4_mem_be), .mem_wdata(t4_mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive_req(input logic we, input logic [2:0] typ,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_typ = typ; req_addr = addr; req_wdata = wdata;
  endtask

  // One complete transaction on the default instance
  task automatic do_txn(input vec_t v);
    @(negedge clk);
    drive_req(v.we, v.typ, v.addr, v.wdata);
    chk("ready_idle", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("mem_addr",  mem_addr,  v.e_addr);
    chk("mem_be",    {28'b0, mem_be}, {28'b0, v.e_be});
    chk("mem_wdata", mem_wdata, v.e_wdata);
    chk("mem_we",    {31'b0, mem_we}, {31'b0, v.we});
    for (int w = 0; w < v.waits; w++) begin
      mem_rdata = 32'h5A5A0000 | w;
      chk("mem_req_wait", {31'b0, mem_req}, 32'd1);
      chk("ready_busy",   {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    chk("mem_req_ack", {31'b0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = v.rdata;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0BADF00D;
    chk("resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("resp_data",  resp_data, v.e_data);
    chk("resp_err",   {31'b0, resp_err}, 32'd0);
    chk("resp_typ",   {29'b0, resp_typ}, {29'b0, v.typ});
    chk("mem_req_rsp",{31'b0, mem_req}, 32'd0);
    chk("ready_rsp",  {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    chk("resp_pulse", {31'b0, resp_valid}, 32'd0);
    chk("ready_back", {31'b0, req_ready}, 32'd1);
  endtask

  vec_t vecs[10];
  vec_t v;
  int   cnt16, cnt4, rv16, rv4;

  initial begin
    req_we = 1'b0; req_typ = '0; req_addr = '0; req_wdata = '0;
    vecs[0] = '{1'b0, MEMORY_WRAP_TYP_HU, 32'h1002, 32'h0,        32'hAABBCCDD, 0, 32'h1000, 4'b1111, 32'h0,        32'h0000AABB};
    vecs[1] = '{1'b1, MEMORY_WRAP_TYP_BS, 32'h2003, 32'h12345678, 32'h55555555, 0, 32'h2000, 4'b1000, 32'h78787878, 32'h0};
    vecs[2] = '{1'b0, MEMORY_WRAP_TYP_WS, 32'h3000, 32'h0,        32'hCAFEF00D, 5, 32'h3000, 4'b1111, 32'h0,        32'hCAFEF00D};
    vecs[3] = '{1'b0, MEMORY_WRAP_TYP_BU, 32'h5001, 32'h0,        32'h11223344, 1, 32'h5000, 4'b1111, 32'h0,        32'h00112233};
    vecs[4] = '{1'b1, MEMORY_WRAP_TYP_HS, 32'h6002, 32'h0000ABCD, 32'h55555555, 2, 32'h6000, 4'b1100, 32'hABCDABCD, 32'h0};
    vecs[5] = '{1'b1, MEMORY_WRAP_TYP_WS, 32'h7000, 32'hDEADBEEF, 32'h55555555, 0, 32'h7000, 4'b1111, 32'hDEADBEEF, 32'h0};
    vecs[6] = '{1'b0, 3'd3,               32'h8000, 32'h0,        32'h01020304, 0, 32'h8000, 4'b1111, 32'h0,        32'h01020304};
    vecs[7] = '{1'b0, MEMORY_WRAP_TYP_BS, 32'h9003, 32'h0,        32'h89ABCDEF, 0, 32'h9000, 4'b1111, 32'h0,        32'h00000089};
    vecs[8] = '{1'b1, MEMORY_WRAP_TYP_BU, 32'h2001, 32'h000000FF, 32'h55555555, 1, 32'h2000, 4'b0010, 32'hFFFFFFFF, 32'h0};
    vecs[9] = '{1'b0, MEMORY_WRAP_TYP_HS, 32'hB002, 32'h0,        32'h11223344, 0, 32'hB000, 4'b1111, 32'h0,        32'h00001122};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_ready",  {31'b0, req_ready}, 32'd1);
    chk("rst_mem_req",{31'b0, mem_req}, 32'd0);
    chk("rst_resp_v", {31'b0, resp_valid}, 32'd0);
    chk("rst_be",     {28'b0, mem_be}, 32'd0);
    chk("rst_addr",   mem_addr, 32'd0);
    chk("rst_data",   resp_data, 32'd0);
    chk("rst_we",     {31'b0, mem_we}, 32'd0);

    // Ack while idle is ignored
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    repeat (2) begin
      @(negedge clk);
      chk("idle_ack_resp", {31'b0, resp_valid}, 32'd0);
      chk("idle_ack_req",  {31'b0, mem_req}, 32'd0);
    end
    mem_ack = 1'b0;

    for (int i = 0; i < 10; i++) do_txn(vecs[i]);

    // Misaligned half store and word load
`ifdef MEMORY_MISALIGN_TRAP_EN
    @(negedge clk);
    drive_req(1'b1, MEMORY_WRAP_TYP_HS, 32'h4001, 32'h0000BEEF);
    @(negedge clk);
    req_valid = 1'b0;
    chk("trap_mem_req", {31'b0, mem_req}, 32'd0);
    chk("trap_valid",   {31'b0, resp_valid}, 32'd1);
    chk("trap_err",     {31'b0, resp_err}, 32'd1);
    chk("trap_data",    resp_data, 32'd0);
    @(negedge clk);
    chk("trap_ready",   {31'b0, req_ready}, 32'd1);
    chk("trap_mem_req2",{31'b0, mem_req}, 32'd0);
`else
    v = '{1'b1, MEMORY_WRAP_TYP_HS, 32'h4001, 32'h0000BEEF, 32'h55555555, 0, 32'h4000, 4'b0011, 32'hBEEFBEEF, 32'h0};
    do_txn(v);
    v = '{1'b0, MEMORY_WRAP_TYP_WS, 32'hA002, 32'h0, 32'h12345678, 0, 32'hA000, 4'b1111, 32'h0, 32'h12345678};
    do_txn(v);
`endif

    // Timeout: no ack, both instances
    do_reset();
    @(negedge clk);
    drive_req(1'b0, MEMORY_WRAP_TYP_WS, 32'h100, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    cnt16 = 0; cnt4 = 0; rv16 = 0; rv4 = 0;
    for (int c = 0; c < 24; c++) begin
      if (mem_req) cnt16++;
      if (t4_mem_req) cnt4++;
      if (resp_valid) begin
        rv16++;
        chk("tmo16_err",  {31'b0, resp_err}, 32'd1);
        chk("tmo16_data", resp_data, 32'd0);
      end
      if (t4_resp_valid) begin
        rv4++;
        chk("tmo4_err",  {31'b0, t4_resp_err}, 32'd1);
        chk("tmo4_data", t4_resp_data, 32'd0);
      end
      @(negedge clk);
    end
    chk("tmo4_req_cycles",  cnt4, 32'd4);
    chk("tmo16_req_cycles", cnt16, 32'd16);
    chk("tmo4_resp_count",  rv4, 32'd1);
    chk("tmo16_resp_count", rv16, 32'd1);

    // Ack in the same cycle the 4-cycle timeout would fire: ack wins
    do_reset();
    @(negedge clk);
    drive_req(1'b0, MEMORY_WRAP_TYP_WS, 32'h200, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("tie_req", {31'b0, t4_mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h600DCAFE;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("tie_valid", {31'b0, t4_resp_valid}, 32'd1);
    chk("tie_err",   {31'b0, t4_resp_err}, 32'd0);
    chk("tie_data",  t4_resp_data, 32'h600DCAFE);
    chk("tie16_data", resp_data, 32'h600DCAFE);
    @(negedge clk);

    // Reset in the middle of BUS, then a fresh load right away
    @(negedge clk);
    drive_req(1'b0, MEMORY_WRAP_TYP_WS, 32'hC000, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("midrst_busy", {31'b0, mem_req}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_req",   {31'b0, mem_req}, 32'd0);
    chk("midrst_ready", {31'b0, req_ready}, 32'd1);
    chk("midrst_resp",  {31'b0, resp_valid}, 32'd0);
    v = '{1'b0, MEMORY_WRAP_TYP_WS, 32'hC004, 32'h0, 32'h0F0F0F0F, 0, 32'hC004, 4'b1111, 32'h0, 32'h0F0F0F0F};
    do_txn(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access.md
# memory_access

Load/store access stage that sits directly upstream of the load-extension stage in the memory path. It accepts one core memory request at a time and drives a word-addressed data-memory bus with byte enables and lane-replicated store data. It waits for the bus acknowledge or a timeout, then returns the load word shifted down to bit 0 together with the access type. Its `resp_data`/`resp_typ` feed the extension stage's `in`/`typ` directly.

## Interface
- `TIMEOUT`, default 16: maximum wait cycles for `mem_ack`; 0 disables the timeout.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: core request present.
- `req_ready` out 1: request accepted this cycle when `req_valid` is also high.
- `req_we` in 1: 1 = store, 0 = load.
- `req_typ` in `MEMORY_WRAP_TYP_W`: access type BS/HS/WS/BU/HU; stores use size only.
- `req_addr` in 32: byte address.
- `req_wdata` in `MEMORY_DATA_W`: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse, for loads and stores.
- `resp_data` out `MEMORY_DATA_W`: load word shifted right by 8×addr[1:0]; 0 for stores and errors.
- `resp_typ` out `MEMORY_WRAP_TYP_W`: registered `req_typ`.
- `resp_err` out 1: qualified by `resp_valid`; signals misaligned access or timeout.
- `mem_req` out 1: bus request, held until ack or timeout.
- `mem_we` out 1: bus write.
- `mem_addr` out 32: {req_addr[31:2], 2'b00}.
- `mem_be` out 4: byte enables; 4'b1111 for loads.
- `mem_wdata` out `MEMORY_DATA_W`: lane-replicated store data.
- `mem_ack` in 1: bus completion, sampled only while `mem_req` is high.
- `mem_rdata` in `MEMORY_DATA_W`: read word, valid with `mem_ack`.

## Operation
- FSM states:
  - IDLE: `req_ready`=1; on `req_valid`, latch we/typ/addr/wdata and go to BUS, or to RESP if the request is misaligned and trapping is enabled.
  - BUS: `mem_req`=1. On `mem_ack`, capture the shifted rdata and go to RESP. On the timeout count reaching `TIMEOUT`-1 without ack, set err and go to RESP.
  - RESP: `resp_valid`=1 for exactly one cycle, then go to IDLE.
- Byte lanes, with off = addr[1:0]:
  - Byte access: be = 4'b0001<<off, wdata = {4{wdata[7:0]}}.
  - Half access: be = off[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata[15:0]}}.
  - Word access: be = 4'b1111.
- Load data: `resp_data` = `mem_rdata` >> (8×off), with upper bits zero-filled. No sign or zero extension here; that is the downstream stage's job.
- Misaligned: a half access with off[0]=1, or a word access with off≠0.
- Unknown `req_typ` codes are treated as word accesses.
- The timeout counter is 16 bits wide and is cleared on entry to BUS.
- `mem_ack` outside BUS is ignored.

## Timing
- Reset (`rst_n`=0 at a clock edge): state IDLE, all outputs 0 except `req_ready`=1, counter 0. Reset in BUS drops `mem_req` on the next edge with no response.
- Request accepted at edge N: `mem_req` is high in cycle N+1.
- A `mem_ack` at the earliest possible cycle, N+1, gives `resp_valid` in N+2. Minimum latency is therefore 2 cycles, plus 1 cycle per bus wait state.
- `req_ready`=0 from N+1 until the cycle after `resp_valid`. This allows back-to-back requests every 3 cycles.
- `mem_addr`, `mem_be`, `mem_wdata` and `mem_we` are registered and stable for the whole BUS state.
- Timeout: with `TIMEOUT`=T and no ack, `mem_req` falls after exactly T cycles high, followed by `resp_valid` with `resp_err`=1.
- If `mem_ack` arrives in the same cycle as the timeout, the ack wins.

## Configuration
- Macro `MEMORY_MISALIGN_TRAP_EN`.
- Defined: a misaligned request goes straight to RESP with `resp_err`=1 and no bus cycle. Latency is 1 cycle.
- Undefined: addr[1:0] is masked to the natural alignment of the size (half clears bit 0, word clears both bits) and the access proceeds normally. `resp_err` then only reports timeouts.

## Structure
- The shared header `memory.vh` holds:
  - the existing `MEMORY_DATA_W`, `MEMORY_WRAP_TYP_W` and `MEMORY_WRAP_TYP_*` codes;
  - new state encodings `MEMORY_ACCESS_ST_IDLE/BUS/RESP`;
  - `MEMORY_BE_W` = 4.
- Sub-module `memory_lane`: purely combinational. Inputs are typ, off and wdata; outputs are be, replicated wdata and the misaligned flag. It is reused by the load shift path.

## Test plan
- Load HU at 0x1002, `mem_rdata`=0xAABBCCDD, ack in first BUS cycle: `mem_addr`=0x1000, `mem_be`=4'b1111, `resp_data`=0x0000AABB, `resp_typ`=HU, `resp_valid` 2 cycles after accept.
- Store BS at 0x2003, wdata=0x12345678: `mem_be`=4'b1000, `mem_wdata`=0x78787878, `mem_we`=1, then `resp_valid` with `resp_err`=0.
- Load WS at 0x3000 with ack after 5 wait states: `mem_req` high 6 cycles, `req_ready` low throughout, `resp_data`=`mem_rdata`.
- `TIMEOUT`=4, no ack: `mem_req` high exactly 4 cycles, then `resp_valid`=1, `resp_err`=1, `resp_data`=0.
- Half store at 0x4001, with and without `MEMORY_MISALIGN_TRAP_EN`:
  - Defined: `resp_err`=1 after 1 cycle and `mem_req` never asserted.
  - Undefined: `mem_addr`=0x4000 and `mem_be`=4'b0011.
- `rst_n`=0 in the middle of BUS: `mem_req`=0 and `req_ready`=1 after the edge, no `resp_valid`. A new load is accepted in the next cycle.
